wptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. It keeps the binary write pointer and produces the RAM write address and the Gray-coded write pointer sent to the write-to-read synchronizer. It consumes the read pointer already synchronized into the write clock domain and derives the full, almost-full, fill-level and overflow status. All logic runs on `wrclk`; the matching read-side block mirrors it on the read clock.

---
 rtl/afifo_pkg.sv | 17 +
 rtl/wptr_full.sv | 58 +++++
 tb/tb_wptr_full.sv | 118 +++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// afifo_pkg: pointer-width convention and Gray/binary conversions shared by both FIFO pointer blocks
package afifo_pkg;
  localparam int PtrMax = 32;
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
  // Operands are zero-extended to PtrMax; leading zeros do not disturb either conversion.
  function automatic logic [PtrMax-1:0] bin2gray(input logic [PtrMax-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PtrMax-1:0] gray2bin(input logic [PtrMax-1:0] g);
    logic [PtrMax-1:0] b;
    b = g;
    for (int i = PtrMax - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/wptr_full.sv
// wptr_full: write-domain pointer, Gray pointer export and full/almost-full/fill/overflow status
module wptr_full
  import afifo_pkg::*;
#(
  parameter int Addr_Width         = 8,
  parameter int Almost_Full_Thresh = 2**Addr_Width - 4
) (
  input  logic                  wrclk,
  input  logic                  wr_rst_n,
  input  logic                  winc,
  input  logic [Addr_Width:0]   rptr_sync,
  output logic [Addr_Width-1:0] waddr,
  output logic [Addr_Width:0]   wptr,
  output logic                  wen,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [Addr_Width:0]   wfill,
  output logic                  wovf
);
  localparam int PW = ptr_width(Addr_Width);
  localparam logic [PW-1:0] AfThresh = PW'(Almost_Full_Thresh);
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wfill_q, wfill_d, rbin;
  logic wfull_q, wfull_d, waf_q, waf_d, wovf_q, wovf_d;
  always_comb begin
    wen     = winc & ~wfull_q & wr_rst_n;
    wbin_d  = wbin_q + PW'(wen);
    wgray_d = PW'(bin2gray(PtrMax'(wbin_d)));
    rbin    = PW'(gray2bin(PtrMax'(rptr_sync)));
    // Full when the next write pointer is one whole lap ahead of the read pointer.
    wfull_d = wgray_d == {~rptr_sync[Addr_Width:Addr_Width-1], rptr_sync[Addr_Width-2:0]};
    wfill_d = wbin_d - rbin;
    waf_d   = wfill_d >= AfThresh;
    wovf_d  = wovf_q | (winc & wfull_q);
  end
  always_ff @(posedge wrclk) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfill_q <= '0;
      wfull_q <= 1'b0;
      waf_q   <= 1'b0;
      wovf_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfill_q <= wfill_d;
      wfull_q <= wfull_d;
      waf_q   <= waf_d;
      wovf_q  <= wovf_d;
    end
  end
  assign waddr        = wbin_q[Addr_Width-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wfill        = wfill_q;
  assign wovf         = wovf_q;
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: scoreboard bench for wptr_full (depth 4) against a write/read-count model
module tb_wptr_full;
  logic clk = 1'b0, rst_n = 1'b0, winc = 1'b0;
  logic [2:0] rptr_sync = '0;
  logic [1:0] waddr;
  logic [2:0] wptr, wfill;
  logic wen, wfull, walmost_full, wovf;
  typedef struct {
    logic wen;
    int   waddr, wptr, fill;
    logic full, af, ovf;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int wcount = 0, rcount = 0;
  logic full_m = 1'b0, ovf_m = 1'b0;
  wptr_full #(.Addr_Width(2), .Almost_Full_Thresh(3)) dut (
    .wrclk(clk), .wr_rst_n(rst_n), .winc(winc), .rptr_sync(rptr_sync),
    .waddr(waddr), .wptr(wptr), .wen(wen), .wfull(wfull),
    .walmost_full(walmost_full), .wfill(wfill), .wovf(wovf)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] gray(input int v);
    logic [2:0] b;
    b = 3'(v % 8);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: fill is simply accepted writes minus reads the write side has seen.
  task automatic step(input logic wi, input int rc, input logic rn);
    exp_t e;
    @(posedge clk);
    #2;
    winc = wi;
    rst_n = rn;
    rcount = rc;
    rptr_sync = gray(rc);
    e.wen = rn && wi && !full_m;
    if (!rn) begin
      wcount = 0;
      full_m = 1'b0;
      ovf_m = 1'b0;
      e.fill = 0;
    end else begin
      ovf_m = ovf_m | (wi & full_m);
      if (e.wen) wcount++;
      e.fill = wcount - rc;
      full_m = e.fill == 4;
    end
    e.af = e.fill >= 3;
    e.full = full_m;
    e.ovf = ovf_m;
    e.waddr = wcount % 4;
    e.wptr = int'(gray(wcount));
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wen", int'(wen), int'(e.wen));
        @(posedge clk);
        #1;
        chk("waddr", int'(waddr), e.waddr);
        chk("wptr", int'(wptr), e.wptr);
        chk("wfull", int'(wfull), int'(e.full));
        chk("walmost_full", int'(walmost_full), int'(e.af));
        chk("wfill", int'(wfill), e.fill);
        chk("wovf", int'(wovf), int'(e.ovf));
      end
    end
  end
  initial begin : driver
    int budget;
    int rc;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    for (int i = 0; i < 20; i++) step(i % 2 == 0, wcount - 1, 1);
    step(0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      rc = rcount;
      if (rc < wcount && $urandom_range(0, 9) < 4) rc++;
      if ($urandom_range(0, 59) == 0) step(1, 0, 0);
      else step($urandom_range(0, 9) < 6, rc, 1);
    end
    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
    end
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
